// File: rtl/sieve_pkg.sv
// Shared definitions for the sieve block-RAM producer and reader.
// Both ends use the same entry encoding: PRIME_MARK means "never marked", so the index is prime.
package sieve_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WAIT = 3'd2,
    EMIT = 3'd3,
    DONE = 3'd4
  } sieve_state_e;

  localparam int PRIME_MARK = 0;

endpackage

// File: rtl/sieve_reader.sv
// sieve_reader: scans the sieve block RAM from FIRST to the top address and streams every
// unmarked (prime) index on a valid/ready port. The RAM port is driven read-only.
// Optional feature: define SIEVE_READER_COUNT_EN to add out__count, the number of primes
// accepted by the consumer during the current scan.
module sieve_reader
  import sieve_pkg::*;
#(
  parameter int ADDR  = 8,
  parameter int DATA  = 8,
  parameter int FIRST = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in__start,
  output logic [ADDR-1:0] out__addr,
  output logic            out__wr,
  output logic [DATA-1:0] out__dout,
  input  logic [DATA-1:0] in__din,
  output logic            out__valid,
  input  logic            in__ready,
  output logic [ADDR-1:0] out__prime,
  output logic            out__busy,
  output logic            out__done
`ifdef SIEVE_READER_COUNT_EN
  ,
  output logic [ADDR:0]   out__count
`endif
);

  // A starting index outside the RAM would make the scan meaningless.
  if (FIRST >= (1 << ADDR) || FIRST < 0) begin : g_first_check
    $error("sieve_reader: FIRST must lie inside the RAM address range");
  end

  localparam logic [ADDR-1:0] FIRST_A = ADDR'(FIRST);
  localparam logic [ADDR-1:0] LAST_A  = {ADDR{1'b1}};
  localparam logic [DATA-1:0] MARK_D  = DATA'(PRIME_MARK);

  sieve_state_e    state_q, state_d;
  logic [ADDR-1:0] addr_q, addr_d;
  logic [ADDR-1:0] prime_q, prime_d;
  logic            valid_q, valid_d;
  logic            start_ok;
  logic            is_last;
  logic            accept;

  assign start_ok = in__start && (state_q == IDLE || state_q == DONE);
  assign is_last  = (addr_q == LAST_A);
  assign accept   = (state_q == EMIT) && in__ready;

  // Next-state logic: one read per address, with an extra EMIT stop for each prime found.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    prime_d = prime_q;
    valid_d = valid_q;
    case (state_q)
      IDLE, DONE: begin
        if (in__start) begin
          state_d = READ;
          addr_d  = FIRST_A;
        end
      end
      READ: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (in__din == MARK_D) begin
          state_d = EMIT;
          valid_d = 1'b1;
          prime_d = addr_q;
        end else if (is_last) begin
          state_d = DONE;
        end else begin
          state_d = READ;
          addr_d  = addr_q + 1'b1;
        end
      end
      EMIT: begin
        if (in__ready) begin
          valid_d = 1'b0;
          if (is_last) begin
            state_d = DONE;
          end else begin
            state_d = READ;
            addr_d  = addr_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any scan in progress.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      prime_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      prime_q <= prime_d;
      valid_q <= valid_d;
    end
  end

`ifdef SIEVE_READER_COUNT_EN
  logic [ADDR:0] count_q, count_d;

  // Accepted-prime counter, restarted by every start that actually begins a scan.
  always_comb begin
    count_d = count_q;
    if (start_ok) begin
      count_d = '0;
    end else if (accept) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign out__count = count_q;
`endif

  assign out__addr  = addr_q;
  assign out__wr    = 1'b0;
  assign out__dout  = '0;
  assign out__valid = valid_q;
  assign out__prime = prime_q;
  assign out__busy  = (state_q == READ) || (state_q == WAIT) || (state_q == EMIT);
  assign out__done  = (state_q == DONE);

endmodule

// File: tb/tb_sieve_reader.sv
// Testbench for sieve_reader: a behavioural RAM, a reference list of primes pushed into a
// scoreboard queue at each start, and a monitor that pops and compares on every handshake.
module tb_sieve_reader;

  localparam int ADDR  = 8;
  localparam int DATA  = 8;
  localparam int FIRST = 2;
  localparam int TOP   = (1 << ADDR) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic            ready = 1'b1;
  logic [ADDR-1:0] addr;
  logic            wr;
  logic [DATA-1:0] dout;
  logic [DATA-1:0] din = '0;
  logic            valid;
  logic [ADDR-1:0] prime;
  logic            busy;
  logic            done;
`ifdef SIEVE_READER_COUNT_EN
  logic [ADDR:0]   count;
`endif

  logic [DATA-1:0] mem [1 << ADDR];
  int exp_q[$];
  int exp_n = 0;
  int checks = 0;
  int errors = 0;
  int ready_mode = 0;
  int hold_prime = -1;
  bit prev_stall = 1'b0;
  int prev_prime = 0;

  sieve_reader #(.ADDR(ADDR), .DATA(DATA), .FIRST(FIRST)) dut (
    .clk        (clk),
    .rst        (rst),
    .in__start  (start),
    .out__addr  (addr),
    .out__wr    (wr),
    .out__dout  (dout),
    .in__din    (din),
    .out__valid (valid),
    .in__ready  (ready),
    .out__prime (prime),
    .out__busy  (busy),
    .out__done  (done)
`ifdef SIEVE_READER_COUNT_EN
    ,
    .out__count (count)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: data for the presented address appears one cycle later.
  always @(posedge clk) din <= mem[addr];

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Monitor: RAM-port invariants, output stability under stall, scoreboard pop on handshake.
  always @(negedge clk) begin
    check("wr_dout_zero", {23'd0, wr, dout}, 0);
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (busy) check("addr_in_range", int'(addr >= FIRST), 1);
      if (prev_stall) begin
        check("hold_valid", int'(valid), 1);
        check("hold_prime", int'(prime), prev_prime);
      end
      if (valid && ready) begin
        if (exp_q.size() == 0) check("unexpected_prime", int'(prime), -1);
        else check("prime", int'(prime), exp_q.pop_front());
      end
      prev_stall = valid && !ready;
      prev_prime = int'(prime);
    end
  end

  // Consumer ready pattern: always, never, random, or stall on one chosen prime.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: ready = 1'b1;
        1: ready = 1'b0;
        2: ready = 1'($urandom_range(0, 1));
        default: ready = !(valid && int'(prime) == hold_prime);
      endcase
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  function automatic bit is_prime(int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++) if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic load_sieve();
    for (int i = 0; i <= TOP; i++) mem[i] = is_prime(i) ? 8'h00 : 8'h01;
  endtask

  task automatic load_composite();
    for (int i = 0; i <= TOP; i++) mem[i] = 8'($urandom_range(1, 255));
  endtask

  task automatic load_random();
    for (int i = 0; i <= TOP; i++)
      mem[i] = ($urandom_range(0, 99) < 30) ? 8'h00 : 8'($urandom_range(1, 255));
  endtask

  // Reference model: every index from FIRST to the top whose entry is zero, in order.
  task automatic push_expected();
    exp_n = 0;
    for (int i = FIRST; i <= TOP; i++)
      if (mem[i] == 8'h00) begin
        exp_q.push_back(i);
        exp_n++;
      end
  endtask

  // Called #1 after a posedge; start is sampled at the next edge, returns #1 after it.
  task automatic apply_stimulus();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, output int cycles);
    cycles = 0;
    while (!done && cycles < max_cycles) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic check_output(input string tag);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    check({tag, "_done"}, int'(done), 1);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_valid"}, int'(valid), 0);
`ifdef SIEVE_READER_COUNT_EN
    check({tag, "_count"}, int'(count), exp_n);
`endif
  endtask

  initial begin
    int cyc;
    bit found;
    load_sieve();
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", int'(addr), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_prime", int'(prime), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
`ifdef SIEVE_READER_COUNT_EN
    check("rst_count", int'(count), 0);
`endif
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Full sieve with ready held high, including first-result latency.
    ready_mode = 0;
    push_expected();
    check("sieve_prime_total", exp_n, 54);
    apply_stimulus();
    check("lat_addr_first", int'(addr), FIRST);
    check("lat_busy", int'(busy), 1);
    check("lat_done_clear", int'(done), 0);
    @(posedge clk);
    #1;
    check("lat_valid_t1", int'(valid), 0);
    @(posedge clk);
    #1;
    check("lat_valid_t2", int'(valid), 1);
    check("lat_prime_t2", int'(prime), 2);
    wait_done(3000, cyc);
    check_output("full");

    // Backpressure: stall five cycles on prime 7; the address must not move.
    ready_mode = 3;
    hold_prime = 7;
    push_expected();
    apply_stimulus();
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (valid && prime == 8'd7) found = 1'b1;
    end
    check("bp_reached_7", int'(found), 1);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", int'(valid), 1);
      check("bp_prime", int'(prime), 7);
      check("bp_addr", int'(addr), 7);
      @(negedge clk);
    end
    ready_mode = 0;
    wait_done(3000, cyc);
    check_output("bp");

    // All entries composite: no output, done after two cycles per address.
    load_composite();
    push_expected();
    apply_stimulus();
    wait_done(3000, cyc);
    check("composite_done_latency", cyc, 2 * (TOP + 1 - FIRST));
    check_output("composite");

    // Reset while prime 13 is being offered.
    load_sieve();
    ready_mode = 3;
    hold_prime = 13;
    push_expected();
    apply_stimulus();
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (valid && prime == 8'd13) found = 1'b1;
    end
    check("rstmid_reached_13", int'(found), 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rstmid_valid", int'(valid), 0);
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_done", int'(done), 0);
    check("rstmid_addr", int'(addr), 0);
    exp_q.delete();
    rst = 1'b1;
    ready_mode = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      check("rstmid_idle_valid", int'(valid), 0);
      check("rstmid_idle_busy", int'(busy), 0);
    end

    // Random ready, spurious starts during the scan, then a restart from DONE.
    ready_mode = 2;
    push_expected();
    apply_stimulus();
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(10, 60)) @(posedge clk);
      #1;
      if (busy) apply_stimulus();
    end
    wait_done(5000, cyc);
    check_output("ignored_start");
    push_expected();
    apply_stimulus();
    check("restart_done_clear", int'(done), 0);
    check("restart_busy", int'(busy), 1);
    check("restart_addr", int'(addr), FIRST);
    wait_done(5000, cyc);
    check_output("restart");

    // Random RAM contents with random backpressure.
    for (int r = 0; r < 3; r++) begin
      load_random();
      push_expected();
      apply_stimulus();
      wait_done(5000, cyc);
      check_output("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
